// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto an incrementing 8-bit counter stream
// and reports mismatches, wrap-arounds and the last accepted sample.
module count_seq_checker #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_valid,
   input  logic [7:0]  din,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_cnt,
   output logic [7:0]  wrap_cnt,
   output logic [7:0]  last_val
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

   state_t      state_q, state_d;
   logic [3:0]  match_cnt_q, match_cnt_d;
   logic [3:0]  miss_cnt_q, miss_cnt_d;
   logic [7:0]  last_val_q, last_val_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [7:0]  wrap_cnt_q, wrap_cnt_d;
   logic        err_pulse_q, err_pulse_d;

   logic [7:0]  expect_val;
   logic        match;
   logic        is_wrap;

   assign expect_val = last_val_q + 8'd1;
   assign match      = (din == expect_val);
   assign is_wrap    = (last_val_q == 8'hFF) && (din == 8'h00);

   // next-state, counters and error pulse for the accepted sample
   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      last_val_d  = last_val_q;
      err_cnt_d   = err_cnt_q;
      wrap_cnt_d  = wrap_cnt_q;
      err_pulse_d = 1'b0;
      if (din_valid) begin
         last_val_d = din;
         unique case (state_q)
            IDLE: begin
               match_cnt_d = 4'd0;
               miss_cnt_d  = 4'd0;
               state_d     = SYNC;
            end
            SYNC: begin
               if (match) begin
                  match_cnt_d = match_cnt_q + 4'd1;
                  if (match_cnt_d >= LOCK_C) begin
                     state_d     = LOCKED;
                     match_cnt_d = 4'd0;
                     miss_cnt_d  = 4'd0;
                  end
               end else begin
                  match_cnt_d = 4'd0;
               end
            end
            LOCKED: begin
               if (match) begin
                  miss_cnt_d = 4'd0;
                  if (is_wrap) begin
                     wrap_cnt_d = wrap_cnt_q + 8'd1;
                  end
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != 16'hFFFF) begin
                     err_cnt_d = err_cnt_q + 16'd1;
                  end
                  miss_cnt_d = miss_cnt_q + 4'd1;
                  if (miss_cnt_d >= LOSS_C) begin
                     state_d     = SYNC;
                     match_cnt_d = 4'd0;
                     miss_cnt_d  = 4'd0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         match_cnt_q <= 4'd0;
         miss_cnt_q  <= 4'd0;
         last_val_q  <= 8'd0;
         err_cnt_q   <= 16'd0;
         wrap_cnt_q  <= 8'd0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         last_val_q  <= last_val_d;
         err_cnt_q   <= err_cnt_d;
         wrap_cnt_q  <= wrap_cnt_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign wrap_cnt  = wrap_cnt_q;
   assign last_val  = last_val_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed scenarios plus randomized stream
// compared against a behavioural model of the counter checker.
module tb_count_seq_checker;

   localparam int LOCK_N = 4;
   localparam int LOSS_N = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        din_valid = 1'b0;
   logic [7:0]  din = 8'd0;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [7:0]  wrap_cnt;
   logic [7:0]  last_val;

   int total = 0;
   int bad = 0;

   // behavioural model
   bit m_seen;
   bit m_lock;
   int m_run;
   int m_miss;
   int m_last;
   int m_err;
   int m_wrap;
   bit m_pulse;

   count_seq_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
      .clk(clk),
      .rst(rst),
      .din_valid(din_valid),
      .din(din),
      .locked(locked),
      .err_pulse(err_pulse),
      .err_cnt(err_cnt),
      .wrap_cnt(wrap_cnt),
      .last_val(last_val)
   );

   always #5 clk = ~clk;

   function automatic void model(bit r, bit v, int d);
      bit ok;
      if (!r) begin
         m_seen = 0; m_lock = 0; m_run = 0; m_miss = 0;
         m_last = 0; m_err = 0; m_wrap = 0; m_pulse = 0;
         return;
      end
      m_pulse = 0;
      if (!v) return;
      ok = (d == (m_last + 1) % 256);
      if (!m_seen) begin
         m_seen = 1;
         m_run = 0;
      end else if (!m_lock) begin
         if (ok) begin
            m_run++;
            if (m_run >= LOCK_N) begin
               m_lock = 1;
               m_miss = 0;
            end
         end else begin
            m_run = 0;
         end
      end else begin
         if (ok) begin
            m_miss = 0;
            if (m_last == 255 && d == 0) m_wrap = (m_wrap + 1) % 256;
         end else begin
            m_pulse = 1;
            if (m_err < 65535) m_err++;
            m_miss++;
            if (m_miss >= LOSS_N) begin
               m_lock = 0;
               m_run = 0;
               m_miss = 0;
            end
         end
      end
      m_last = d;
   endfunction

   // one clock: drive inputs, advance model at the edge, settle
   task automatic cyc(input bit r, input bit v, input int d);
      rst = r;
      din_valid = v;
      din = 8'(d);
      @(posedge clk);
      model(r, v, d);
      #1;
   endtask

   task automatic test_reset();
      cyc(0, 1, 77);
      cyc(0, 0, 0);
      total++;
      if ({locked, err_pulse, err_cnt, wrap_cnt, last_val} !== 34'd0) begin
         bad++;
         $display("FAIL reset: got lk=%b ep=%b ec=%0d wc=%0d lv=%0d want all 0",
                  locked, err_pulse, err_cnt, wrap_cnt, last_val);
      end
   endtask

   task automatic test_lock();
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      for (int i = 10; i <= 13; i++) cyc(1, 1, i);
      total++;
      if (locked !== 1'b0) begin
         bad++;
         $display("FAIL lock_early: locked=%b want 0", locked);
      end
      cyc(1, 1, 14);
      total++;
      if (locked !== 1'b1 || err_cnt !== 16'd0 || last_val !== 8'd14) begin
         bad++;
         $display("FAIL lock: lk=%b ec=%0d lv=%0d want 1 0 14",
                  locked, err_cnt, last_val);
      end
   endtask

   task automatic test_wrap();
      bit saw_err;
      cyc(0, 0, 0);
      for (int i = 249; i <= 253; i++) cyc(1, 1, i);
      saw_err = 0;
      cyc(1, 1, 254); saw_err |= err_pulse;
      cyc(1, 1, 255); saw_err |= err_pulse;
      cyc(1, 1, 0);   saw_err |= err_pulse;
      cyc(1, 1, 1);   saw_err |= err_pulse;
      total++;
      if (wrap_cnt !== 8'd1 || saw_err !== 1'b0 || locked !== 1'b1) begin
         bad++;
         $display("FAIL wrap: wc=%0d err=%b lk=%b want 1 0 1",
                  wrap_cnt, saw_err, locked);
      end
   endtask

   task automatic test_upstream_reset();
      cyc(0, 0, 0);
      for (int i = 36; i <= 40; i++) cyc(1, 1, i);
      cyc(1, 1, 0);
      total++;
      if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
         bad++;
         $display("FAIL upstream: ep=%b ec=%0d lk=%b want 1 1 1",
                  err_pulse, err_cnt, locked);
      end
      cyc(1, 1, 1);
      total++;
      if (err_pulse !== 1'b0) begin
         bad++;
         $display("FAIL upstream_pulse: ep=%b want 0", err_pulse);
      end
      cyc(1, 1, 2);
      cyc(1, 1, 100);
      cyc(1, 1, 200);
      total++;
      if (locked !== 1'b1 || err_cnt !== 16'd3) begin
         bad++;
         $display("FAIL miss_clear: lk=%b ec=%0d want 1 3", locked, err_cnt);
      end
   endtask

   task automatic test_loss();
      int ec0;
      int pulses;
      cyc(1, 1, 201);
      ec0 = int'(err_cnt);
      pulses = 0;
      cyc(1, 1, 50); pulses += int'(err_pulse);
      cyc(1, 1, 90); pulses += int'(err_pulse);
      total++;
      if (locked !== 1'b1) begin
         bad++;
         $display("FAIL loss_early: lk=%b want 1", locked);
      end
      cyc(1, 1, 7);  pulses += int'(err_pulse);
      total++;
      if (pulses != 3 || int'(err_cnt) != ec0 + 3 || locked !== 1'b0) begin
         bad++;
         $display("FAIL loss: pulses=%0d ec=%0d lk=%b want 3 %0d 0",
                  pulses, err_cnt, locked, ec0 + 3);
      end
      for (int i = 8; i <= 11; i++) cyc(1, 1, i);
      total++;
      if (locked !== 1'b1) begin
         bad++;
         $display("FAIL loss_sync: lk=%b want 1", locked);
      end
   endtask

   task automatic test_gaps();
      bit saw_err;
      bit dropped;
      cyc(0, 0, 0);
      for (int i = 16; i <= 19; i++) cyc(1, 1, i);
      saw_err = 0;
      dropped = 0;
      cyc(1, 1, 20); saw_err |= err_pulse;
      cyc(1, 1, 21); saw_err |= err_pulse;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, $urandom_range(255));
         saw_err |= err_pulse;
         dropped |= ~locked;
      end
      total++;
      if (last_val !== 8'd21) begin
         bad++;
         $display("FAIL gap_hold: lv=%0d want 21", last_val);
      end
      cyc(1, 1, 22); saw_err |= err_pulse;
      dropped |= ~locked;
      total++;
      if (saw_err !== 1'b0 || dropped !== 1'b0 || last_val !== 8'd22) begin
         bad++;
         $display("FAIL gaps: err=%b drop=%b lv=%0d want 0 0 22",
                  saw_err, dropped, last_val);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1, 1, 23);
      cyc(0, 1, 99);
      total++;
      if ({locked, err_pulse, err_cnt, wrap_cnt, last_val} !== 34'd0) begin
         bad++;
         $display("FAIL rst_mid: lk=%b ep=%b ec=%0d wc=%0d lv=%0d want 0",
                  locked, err_pulse, err_cnt, wrap_cnt, last_val);
      end
      cyc(1, 0, 0);
      total++;
      if (err_pulse !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_pulse: ep=%b want 0", err_pulse);
      end
      for (int i = 5; i <= 8; i++) cyc(1, 1, i);
      total++;
      if (locked !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_idle: lk=%b want 0", locked);
      end
      cyc(1, 1, 9);
      total++;
      if (locked !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_relock: lk=%b want 1", locked);
      end
   endtask

   task automatic test_random();
      int sel;
      int d;
      bit r;
      bit v;
      cyc(0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         sel = int'($urandom_range(99));
         if (sel < 72)      d = (m_last + 1) % 256;
         else if (sel < 80) d = 0;
         else if (sel < 85) d = 255;
         else               d = int'($urandom_range(255));
         v = ($urandom_range(99) < 80);
         r = ($urandom_range(299) != 0);
         cyc(r, v, d);
         total++;
         if (locked !== m_lock || err_pulse !== m_pulse ||
             err_cnt !== 16'(m_err) || wrap_cnt !== 8'(m_wrap) ||
             last_val !== 8'(m_last)) begin
            bad++;
            $display("FAIL random[%0d]: got %b %b %0d %0d %0d want %b %b %0d %0d %0d",
                     n, locked, err_pulse, err_cnt, wrap_cnt, last_val,
                     m_lock, m_pulse, m_err, m_wrap, m_last);
         end
      end
   endtask

   initial begin
      model(0, 0, 0);
      test_reset();
      test_lock();
      test_wrap();
      test_upstream_reset();
      test_loss();
      test_gaps();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
